seven_seg_monitor: RTL and testbench
====================================

// Module: seven_seg_monitor
// PURPOSE
// - Observing end of the multiplexed 7-seg bus: watches seg/an as driven to the display, rebuilds the four digit patterns.
// - Flags digits blanked by flashing, decodes patterns to hex.
// - Used for self-check/loopback on board and as the scoreboard front end in display benches.
// - Same clock as the scan driver; no synchroniser.
// PARAMETERS
// - FRAME_CYCLES   16  observation window in clk_in cycles, >=4; blank flags and frame_stb resolve once per window
// - STABLE_CYCLES  1   consecutive identical {an,seg} samples required before capture (glitch filter), >=1
// - SEG_ACTIVE_LOW 1   1: seg bit low = segment lit; 0: high = lit. Internally normalised to lit=1
// PORTS
// - clk_in         in   1   system clock
// - rst_n          in   1   asynchronous reset, active low
// - seg            in   7   segment bus, seg[0]=a ... seg[6]=g
// - an             in   4   anode bus, active low; an[3]=digit1 (leftmost) ... an[0]=digit4
// - cap_digit1..4  out  7x4 last captured raw seg pattern per position, as on the bus
// - hex            out  16  decoded values, [15:12]=digit1 ... [3:0]=digit4
// - hex_ok         out  4   per-position decode valid, bit i tracks an[i]
// - blanked        out  4   position not lit at all during last window, bit i tracks an[i]
// - frame_stb      out  1   one-cycle pulse at window end; blanked is updated on the same edge
// - err_multi      out  1   sticky: more than one anode low was seen
// BEHAVIOUR
// - Reset (async, rst_n=0): cap_digit* = 7'h7F if SEG_ACTIVE_LOW else 7'h00; hex=0; hex_ok=0; blanked=0; frame_stb=0;
//   err_multi=0; window counter, seen mask, stability counter cleared. Reset mid-window discards the partial window.
// - Sample classes, every cycle: exactly one an bit low = valid slot; an=4'hF = blank slot; >=2 low = illegal.
// - Stability: stab_cnt counts consecutive cycles with {an,seg} equal to the previous cycle and valid; a change resets it to 1.
//   Capture when stab_cnt >= STABLE_CYCLES, i.e. on the STABLE_CYCLES-th matching sample.
//   Outputs visible the next cycle; latency 1 when STABLE_CYCLES=1. Re-capture of the same value each cycle is allowed.
// - Capture: cap_digit[pos] <= seg; seen[pos] <= 1; hex[pos] and hex_ok[pos] are updated on the same edge.
// - Blank or illegal slot: no capture; cap_digit/hex hold.
// - Illegal slot: err_multi <= 1, cleared only by reset.
// - Window: counter 0..FRAME_CYCLES-1, wraps to 0.
//   - On the edge where counter = FRAME_CYCLES-1: blanked <= ~seen_next (includes any capture that same cycle);
//     seen <= 0; frame_stb <= 1 for one cycle.
// - Simultaneous events: capture and window end on the same edge both apply; capture counts toward the closing window.
//   Illegal sample at window end sets err_multi and still closes the window.
// - Decode (lit-normalised, gfedcba): standard Basys3 table 0-9 and A,b,C,d,E,F.
//   - Any other pattern, incl. all-off: hex nibble=0, hex_ok bit=0.
// - All state is registered; no combinational path from seg/an to outputs.
// CONFIGURATION
// - SEG_MON_DECODE_EN defined: decoder present, hex/hex_ok behave as above.
// - SEG_MON_DECODE_EN undefined: no decoder logic; hex tied 16'h0000, hex_ok tied 4'b0000. Capture, blank and error logic unchanged.
// TESTING
// - Reset: rst_n=0 mid-scan -> all outputs at reset values immediately (async); after release, frame_stb first pulses
//   FRAME_CYCLES cycles later.
// - Scan an=0111,1011,1101,1110 repeating with active-low seg=7'b1111001,0100100,0110000,0011001 for 16 cycles (DECODE_EN):
//   -> frame_stb pulse; hex=16'h1234; hex_ok=4'hF; blanked=4'h0; cap_digit1=7'b1111001.
// - Flash: same scan but an=4'hF in every digit2 slot for a full window -> blanked=4'b0100; cap_digit2 and hex[11:8]
//   hold prior values; others unchanged.
// - Illegal: one cycle an=4'b0011 -> err_multi=1 from next cycle onward; no cap_digit changes; err_multi stays 1 until reset.
// - Glitch, STABLE_CYCLES=2: single-cycle an=0111 seg=7'b0000000 between stable '1' slots -> cap_digit1 stays 7'b1111001.
//   The same pattern held 2 cycles -> cap_digit1=7'b0000000, hex[15:12]=4'h8.
// - Unknown/macro: seg=7'b1111110 on digit4 -> hex_ok[0]=0, hex[3:0]=0.
//   Rebuild without SEG_MON_DECODE_EN, rerun the 1234 scan -> hex=0, hex_ok=0, cap_digit* still correct.

Source files
------------

// File: rtl/seven_seg_monitor.sv
`default_nettype none
// ============================================================================
// Module  : seven_seg_monitor
// Brief   : Observes a multiplexed 7-seg bus and rebuilds the four digits.
//           Optional hex decoder is built when SEG_MON_DECODE_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module seven_seg_monitor #(
  parameter int FRAME_CYCLES   = 16,
  parameter int STABLE_CYCLES  = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [6:0]  cap_digit1,
  output logic [6:0]  cap_digit2,
  output logic [6:0]  cap_digit3,
  output logic [6:0]  cap_digit4,
  output logic [15:0] hex,
  output logic [3:0]  hex_ok,
  output logic [3:0]  blanked,
  output logic        frame_stb,
  output logic        err_multi
);

  localparam int             CNT_W   = (FRAME_CYCLES > 2) ? $clog2(FRAME_CYCLES) : 1;
  localparam int             STAB_W  = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES);
  localparam logic [6:0]     CAP_RST = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STAB_W-1:0] stab_q, stab_d;
  logic [10:0]       prev_q;
  logic [3:0]        seen_q, seen_d, seen_upd;
  logic [3:0]        blanked_q, blanked_d;
  logic              stb_q, err_q;
  logic [6:0]        cap_q [4];

  logic              w_valid, w_illegal, w_capture, w_win_end;
  logic [1:0]        w_pos;

  // Slot classification: exactly one low anode selects a position.
  always_comb begin
    w_valid   = 1'b1;
    w_illegal = 1'b0;
    w_pos     = 2'd0;
    case (an)
      4'b1110: w_pos = 2'd0;
      4'b1101: w_pos = 2'd1;
      4'b1011: w_pos = 2'd2;
      4'b0111: w_pos = 2'd3;
      4'b1111: w_valid = 1'b0;
      default: begin
        w_valid   = 1'b0;
        w_illegal = 1'b1;
      end
    endcase
  end

  always_comb begin
    stab_d = STAB_W'(1);
    if (w_valid && ({an, seg} == prev_q))
      stab_d = (stab_q == STAB_MAX) ? STAB_MAX : stab_q + 1'b1;
    w_capture = w_valid && (stab_d >= STAB_MAX);
    w_win_end = (cnt_q == CNT_LAST);
    cnt_d     = w_win_end ? '0 : cnt_q + 1'b1;
    seen_upd  = seen_q;
    if (w_capture)
      seen_upd[w_pos] = 1'b1;
    seen_d    = w_win_end ? 4'b0000 : seen_upd;
    blanked_d = w_win_end ? ~seen_upd : blanked_q;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      stab_q    <= '0;
      prev_q    <= '0;
      seen_q    <= 4'b0000;
      blanked_q <= 4'b0000;
      stb_q     <= 1'b0;
      err_q     <= 1'b0;
      for (int i = 0; i < 4; i++)
        cap_q[i] <= CAP_RST;
    end else begin
      cnt_q     <= cnt_d;
      stab_q    <= stab_d;
      prev_q    <= {an, seg};
      seen_q    <= seen_d;
      blanked_q <= blanked_d;
      stb_q     <= w_win_end;
      if (w_illegal)
        err_q <= 1'b1;
      if (w_capture)
        cap_q[w_pos] <= seg;
    end
  end

`ifdef SEG_MON_DECODE_EN
  logic [6:0]  w_lit;
  logic [3:0]  w_nib;
  logic        w_ok;
  logic [15:0] hex_q;
  logic [3:0]  hex_ok_q;

  // Table is in lit=1, gfedcba order.
  always_comb begin
    w_lit = (SEG_ACTIVE_LOW != 0) ? ~seg : seg;
    w_ok  = 1'b1;
    w_nib = 4'h0;
    case (w_lit)
      7'h3F: w_nib = 4'h0;
      7'h06: w_nib = 4'h1;
      7'h5B: w_nib = 4'h2;
      7'h4F: w_nib = 4'h3;
      7'h66: w_nib = 4'h4;
      7'h6D: w_nib = 4'h5;
      7'h7D: w_nib = 4'h6;
      7'h07: w_nib = 4'h7;
      7'h7F: w_nib = 4'h8;
      7'h6F: w_nib = 4'h9;
      7'h77: w_nib = 4'hA;
      7'h7C: w_nib = 4'hB;
      7'h39: w_nib = 4'hC;
      7'h5E: w_nib = 4'hD;
      7'h79: w_nib = 4'hE;
      7'h71: w_nib = 4'hF;
      default: w_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      hex_q    <= 16'h0000;
      hex_ok_q <= 4'b0000;
    end else if (w_capture) begin
      hex_q[{w_pos, 2'b00} +: 4] <= w_nib;
      hex_ok_q[w_pos]            <= w_ok;
    end
  end

  assign hex    = hex_q;
  assign hex_ok = hex_ok_q;
`else
  assign hex    = 16'h0000;
  assign hex_ok = 4'b0000;
`endif

  assign cap_digit1 = cap_q[3];
  assign cap_digit2 = cap_q[2];
  assign cap_digit3 = cap_q[1];
  assign cap_digit4 = cap_q[0];
  assign blanked    = blanked_q;
  assign frame_stb  = stb_q;
  assign err_multi  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_monitor.sv
`default_nettype none
// ============================================================================
// Module  : tb_seven_seg_monitor
// Brief   : Directed bench; dut_a uses STABLE_CYCLES=1, dut_b uses 2.
// Revision: 1.0 - initial release
// ============================================================================
module tb_seven_seg_monitor;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic        rst_n;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [6:0]  a_c1, a_c2, a_c3, a_c4, b_c1, b_c2, b_c3, b_c4;
  logic [15:0] a_hex, b_hex;
  logic [3:0]  a_ok, b_ok, a_blk, b_blk;
  logic        a_stb, b_stb, a_err, b_err;

  int checks = 0;
  int errors = 0;

  logic [3:0] scan_an  [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
  logic [6:0] scan_seg [4] = '{7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};

  seven_seg_monitor #(.FRAME_CYCLES(16), .STABLE_CYCLES(1), .SEG_ACTIVE_LOW(1)) dut_a (
    .clk_in(clk_in), .rst_n(rst_n), .seg(seg), .an(an),
    .cap_digit1(a_c1), .cap_digit2(a_c2), .cap_digit3(a_c3), .cap_digit4(a_c4),
    .hex(a_hex), .hex_ok(a_ok), .blanked(a_blk), .frame_stb(a_stb), .err_multi(a_err));

  seven_seg_monitor #(.FRAME_CYCLES(16), .STABLE_CYCLES(2), .SEG_ACTIVE_LOW(1)) dut_b (
    .clk_in(clk_in), .rst_n(rst_n), .seg(seg), .an(an),
    .cap_digit1(b_c1), .cap_digit2(b_c2), .cap_digit3(b_c3), .cap_digit4(b_c4),
    .hex(b_hex), .hex_ok(b_ok), .blanked(b_blk), .frame_stb(b_stb), .err_multi(b_err));

  // Expected decoder outputs collapse to zero when the decoder is not built.
  function automatic logic [15:0] eh(input logic [15:0] v);
`ifdef SEG_MON_DECODE_EN
    return v;
`else
    return 16'h0000;
`endif
  endfunction

  function automatic logic [3:0] eo(input logic [3:0] v);
`ifdef SEG_MON_DECODE_EN
    return v;
`else
    return 4'h0;
`endif
  endfunction

  task automatic drive(input logic [3:0] a, input logic [6:0] s);
    an  = a;
    seg = s;
    @(negedge clk_in);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; an = 4'hF; seg = 7'h7F;
    repeat (2) @(negedge clk_in);
    checks++; if (a_c1 !== 7'h7F || a_c4 !== 7'h7F) begin errors++; $display("FAIL reset_cap got %h/%h want 7f", a_c1, a_c4); end
    checks++; if (a_hex !== 16'h0 || a_ok !== 4'h0) begin errors++; $display("FAIL reset_hex got %h/%h want 0", a_hex, a_ok); end
    checks++; if (a_blk !== 4'h0 || a_stb !== 1'b0 || a_err !== 1'b0) begin errors++; $display("FAIL reset_misc got %b/%b/%b want 0", a_blk, a_stb, a_err); end
    rst_n = 1'b1;
  endtask

  task automatic test_scan;
    for (int i = 0; i < 15; i++) drive(scan_an[i%4], scan_seg[i%4]);
    checks++; if (a_stb !== 1'b0) begin errors++; $display("FAIL scan_stb_early got %b want 0", a_stb); end
    drive(scan_an[3], scan_seg[3]);
    checks++; if (a_stb !== 1'b1) begin errors++; $display("FAIL scan_stb got %b want 1", a_stb); end
    checks++; if (a_hex !== eh(16'h1234)) begin errors++; $display("FAIL scan_hex got %h want %h", a_hex, eh(16'h1234)); end
    checks++; if (a_ok !== eo(4'hF)) begin errors++; $display("FAIL scan_ok got %h want %h", a_ok, eo(4'hF)); end
    checks++; if (a_blk !== 4'h0) begin errors++; $display("FAIL scan_blanked got %b want 0000", a_blk); end
    checks++; if (a_c1 !== 7'b1111001 || a_c2 !== 7'b0100100 || a_c3 !== 7'b0110000 || a_c4 !== 7'b0011001)
      begin errors++; $display("FAIL scan_caps got %b %b %b %b", a_c1, a_c2, a_c3, a_c4); end
    checks++; if (b_blk !== 4'hF || b_c1 !== 7'h7F) begin errors++; $display("FAIL scan_stable2 got blk=%b c1=%b want 1111/1111111", b_blk, b_c1); end
  endtask

  task automatic test_flash;
    drive(scan_an[0], scan_seg[0]);
    checks++; if (a_stb !== 1'b0) begin errors++; $display("FAIL flash_stb_drop got %b want 0", a_stb); end
    for (int i = 1; i < 16; i++) begin
      if (i % 4 == 1) drive(4'hF, 7'h00);
      else            drive(scan_an[i%4], scan_seg[i%4]);
    end
    checks++; if (a_stb !== 1'b1 || a_blk !== 4'b0100) begin errors++; $display("FAIL flash_blanked got stb=%b blk=%b want 1/0100", a_stb, a_blk); end
    checks++; if (a_c2 !== 7'b0100100 || a_c1 !== 7'b1111001 || a_c3 !== 7'b0110000) begin errors++; $display("FAIL flash_hold got %b %b %b", a_c1, a_c2, a_c3); end
    checks++; if (a_hex !== eh(16'h1234)) begin errors++; $display("FAIL flash_hex got %h want %h", a_hex, eh(16'h1234)); end
  endtask

  task automatic test_illegal;
    drive(4'b0011, 7'b0000000);
    checks++; if (a_err !== 1'b1) begin errors++; $display("FAIL illegal_err got %b want 1", a_err); end
    checks++; if (a_c1 !== 7'b1111001 || a_c3 !== 7'b0110000) begin errors++; $display("FAIL illegal_nocap got %b %b", a_c1, a_c3); end
    repeat (3) drive(4'hF, 7'h7F);
    checks++; if (a_err !== 1'b1) begin errors++; $display("FAIL illegal_sticky got %b want 1", a_err); end
  endtask

  task automatic test_glitch;
    repeat (2) drive(4'b0111, 7'b1111001);
    checks++; if (b_c1 !== 7'b1111001) begin errors++; $display("FAIL glitch_setup got %b want 1111001", b_c1); end
    drive(4'b0111, 7'b0000000);
    checks++; if (b_c1 !== 7'b1111001) begin errors++; $display("FAIL glitch_filtered got %b want 1111001", b_c1); end
    checks++; if (a_c1 !== 7'b0000000) begin errors++; $display("FAIL glitch_stable1 got %b want 0000000", a_c1); end
    repeat (2) drive(4'b0111, 7'b1111001);
    drive(4'b0111, 7'b0000000);
    checks++; if (b_c1 !== 7'b1111001) begin errors++; $display("FAIL glitch_first got %b want 1111001", b_c1); end
    drive(4'b0111, 7'b0000000);
    checks++; if (b_c1 !== 7'b0000000) begin errors++; $display("FAIL glitch_held got %b want 0000000", b_c1); end
    checks++; if (b_hex[15:12] !== eh(16'h8000) >> 12 || b_ok[3] !== eo(4'h8) >> 3)
      begin errors++; $display("FAIL glitch_hex got %h/%b", b_hex, b_ok); end
  endtask

  task automatic test_unknown;
    drive(4'b1110, 7'b1111110);
    checks++; if (a_c4 !== 7'b1111110) begin errors++; $display("FAIL unk_cap got %b want 1111110", a_c4); end
    checks++; if (a_hex[3:0] !== 4'h0 || a_ok[0] !== 1'b0) begin errors++; $display("FAIL unk_hex got %h/%b want 0/0", a_hex[3:0], a_ok[0]); end
    checks++; if (a_hex !== eh(16'h8230) || a_ok !== eo(4'b1110)) begin errors++; $display("FAIL unk_others got %h/%b want %h/%b", a_hex, a_ok, eh(16'h8230), eo(4'b1110)); end
  endtask

  task automatic test_reset_midscan;
    for (int i = 0; i < 5; i++) drive(scan_an[i%4], scan_seg[i%4]);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (a_err !== 1'b0 || a_c1 !== 7'h7F || a_c4 !== 7'h7F) begin errors++; $display("FAIL midreset_async got err=%b c1=%h c4=%h", a_err, a_c1, a_c4); end
    checks++; if (a_hex !== 16'h0 || a_ok !== 4'h0 || a_blk !== 4'h0) begin errors++; $display("FAIL midreset_hex got %h/%b/%b want 0", a_hex, a_ok, a_blk); end
    repeat (2) @(negedge clk_in);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) drive(scan_an[i%4], scan_seg[i%4]);
    checks++; if (a_stb !== 1'b0) begin errors++; $display("FAIL midreset_stb_early got %b want 0", a_stb); end
    drive(scan_an[3], scan_seg[3]);
    checks++; if (a_stb !== 1'b1 || a_blk !== 4'h0) begin errors++; $display("FAIL midreset_stb got %b/%b want 1/0000", a_stb, a_blk); end
    checks++; if (a_hex !== eh(16'h1234) || a_c2 !== 7'b0100100) begin errors++; $display("FAIL midreset_scan got %h/%b", a_hex, a_c2); end
  endtask

  initial begin
    test_reset;
    test_scan;
    test_flash;
    test_illegal;
    test_glitch;
    test_unknown;
    test_reset_midscan;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
